// File: rtl/sd_card_test_sequencer.sv
// sd_card_test_sequencer
// UART-driven command sequencer for the SD card driver. Decodes binary
// commands from the UART receiver, issues block write/read requests to the
// card driver, generates test patterns for writes and either dumps read data
// to the UART or verifies it against the regenerated pattern. Every command
// ends with a status byte queued behind any dump data in the TX FIFO.
//
// Commands (IDLE): 'z'+addr write, 'o'+addr dump, 'v'+addr verify,
//                  'p'+mode+seed set pattern, anything else -> '?'.
// Status bytes:    'K' done, 'P' verify pass, 'F'+cnt_hi+cnt_lo verify fail,
//                  'T' driver timeout, '?' unknown command.
//
// Ports:
//   CLOCK50, nRESET            clock (rising edge), async active-low reset
//   RX_STB/RX_DAT              received UART byte (1-cycle strobe)
//   TX_STB/TX_DAT/TX_ACK/TX_RDY  UART transmit request; held until TX_ACK
//   WR_STB/WR_ADDR/WR_ACK      block write request to card driver
//   WD_STB/WD_DATA/WD_ACK      write data stream, one byte per WD_ACK
//   RD_STB/RD_ADDR/RD_ACK      block read request to card driver
//   RES_STB/RES_DATA/RES_BUSY  read data stream; RES_BUSY throttles the driver
//   DBG_STATE                  current FSM state for observation
//
// Optional feature: define SD_TESTER_LFSR_EN to build the mode-2 LFSR
// pattern (x^8+x^6+x^5+x^4+1, shift left). Without it mode 2 is incrementing.
//
// Handshakes: a request STB is held with stable data until its ACK is seen on
// a rising edge; the STB drops (or the data advances) on the following cycle.
module sd_card_test_sequencer #(
  parameter int AW             = 32,
  parameter int ADDR_BYTES     = 4,
  parameter int BLOCK_BYTES    = 512,
  parameter int FIFO_AW        = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic          CLOCK50,
  input  logic          nRESET,
  input  logic          RX_STB,
  input  logic [7:0]    RX_DAT,
  output logic          TX_STB,
  output logic [7:0]    TX_DAT,
  input  logic          TX_ACK,
  input  logic          TX_RDY,
  output logic          WR_STB,
  output logic [AW-1:0] WR_ADDR,
  input  logic          WR_ACK,
  output logic          WD_STB,
  output logic [7:0]    WD_DATA,
  input  logic          WD_ACK,
  output logic          RD_STB,
  output logic [AW-1:0] RD_ADDR,
  input  logic          RD_ACK,
  input  logic          RES_STB,
  input  logic [7:0]    RES_DATA,
  output logic          RES_BUSY,
  output logic [2:0]    DBG_STATE
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARG     = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_WSTREAM = 3'd3;
  localparam logic [2:0] S_RSTREAM = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [7:0] CMD_Z = 8'h7A, CMD_O = 8'h6F, CMD_V = 8'h76, CMD_P = 8'h70;
  localparam logic [7:0] RSP_K = 8'h4B, RSP_P = 8'h50, RSP_F = 8'h46;
  localparam logic [7:0] RSP_T = 8'h54, RSP_Q = 8'h3F;

  localparam int AXW   = ADDR_BYTES * 8;
  localparam int CW    = $clog2(BLOCK_BYTES + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [2:0]       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [3:0]       arg_cnt_q, arg_cnt_d;
  logic [AXW-1:0]   addr_q, addr_d;
  logic [7:0]       mode_q, mode_d, seed_q, seed_d, pat_q, pat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      mis_q, mis_d;
  logic [7:0]       resp_q, resp_d;
  logic [1:0]       resp_idx_q, resp_idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic             tx_stb_q, tx_stb_d, res_busy_q, res_busy_d;
  logic [7:0]       tx_dat_q, tx_dat_d;
  logic [7:0]       fifo_mem [DEPTH];

  logic       push, push_en, pop, fifo_full, fifo_empty, tmo_hit, timeout, last_arg;
  logic [7:0] push_dat, pat_init, pat_step;

  // Pattern generator: start value for a new z/v and the value after one step.
  always_comb begin
    pat_init = seed_q;
    pat_step = (mode_q == 8'd1) ? pat_q : pat_q + 8'd1;
`ifdef SD_TESTER_LFSR_EN
    if (mode_q == 8'd2) begin
      // An all-zero LFSR would lock up, so a zero seed starts at 1.
      pat_init = (seed_q == 8'd0) ? 8'h01 : seed_q;
      pat_step = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
    end
`endif
  end

  assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign last_arg   = (cmd_q == CMD_P) ? (arg_cnt_q == 4'd1)
                                       : (arg_cnt_q == 4'(ADDR_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_cnt_d  = arg_cnt_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
    resp_d     = resp_q;
    resp_idx_d = resp_idx_q;
    tmo_d      = tmo_q + TW'(1);
    push       = 1'b0;
    push_dat   = 8'h00;
    timeout    = 1'b0;

    case (state_q)
      S_IDLE: if (RX_STB) begin
        cmd_d      = RX_DAT;
        arg_cnt_d  = '0;
        resp_idx_d = '0;
        if (RX_DAT == CMD_Z || RX_DAT == CMD_O || RX_DAT == CMD_V || RX_DAT == CMD_P)
          state_d = S_ARG;
        else begin
          resp_d  = RSP_Q;
          state_d = S_RESP;
        end
      end
      S_ARG: if (RX_STB) begin
        arg_cnt_d = arg_cnt_q + 4'd1;
        addr_d    = {addr_q[AXW-9:0], RX_DAT};
        if (last_arg) begin
          if (cmd_q == CMD_P) begin
            mode_d  = addr_q[7:0];
            seed_d  = RX_DAT;
            resp_d  = RSP_K;
            state_d = S_RESP;
          end else begin
            cnt_d   = '0;
            mis_d   = '0;
            pat_d   = pat_init;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (cmd_q == CMD_Z ? WR_ACK : RD_ACK)
          state_d = (cmd_q == CMD_Z) ? S_WSTREAM : S_RSTREAM;
        else if (tmo_hit)
          timeout = 1'b1;
      end
      S_WSTREAM: begin
        if (WD_ACK) begin
          tmo_d = '0;
          pat_d = pat_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
            resp_d  = RSP_K;
            state_d = S_RESP;
          end
        end else if (tmo_hit)
          timeout = 1'b1;
      end
      S_RSTREAM: begin
        if (RES_STB) begin
          tmo_d = '0;
          cnt_d = cnt_q + CW'(1);
          if (cmd_q == CMD_O) begin
            push     = 1'b1;
            push_dat = RES_DATA;
          end else begin
            pat_d = pat_step;
            if (RES_DATA != pat_q && mis_q != 16'hFFFF) mis_d = mis_q + 16'd1;
          end
          if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
            state_d = S_RESP;
            if (cmd_q == CMD_O) resp_d = RSP_K;
            else                resp_d = (mis_d == 16'd0) ? RSP_P : RSP_F;
          end
        end else if (tmo_hit)
          timeout = 1'b1;
      end
      S_RESP: begin
        // Responses wait for room rather than being dropped.
        if (!fifo_full) begin
          push = 1'b1;
          case (resp_idx_q)
            2'd0:    push_dat = resp_q;
            2'd1:    push_dat = mis_q[15:8];
            default: push_dat = mis_q[7:0];
          endcase
          resp_idx_d = resp_idx_q + 2'd1;
          if (resp_q != RSP_F || resp_idx_q == 2'd2) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      cnt_d      = '0;
      mis_d      = '0;
      resp_d     = RSP_T;
      resp_idx_d = '0;
      state_d    = S_RESP;
    end
    if (state_d != state_q) tmo_d = '0;
  end

  // TX FIFO and UART drain. The head byte is latched when TX_STB rises and
  // popped on TX_ACK, so a push takes two edges to reach TX_STB.
  assign push_en = push && !fifo_full;
  assign pop     = tx_stb_q && TX_ACK;

  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_en && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!push_en && pop) count_d = count_q - (FIFO_AW+1)'(1);
    tx_stb_d = tx_stb_q;
    tx_dat_d = tx_dat_q;
    if (!tx_stb_q) begin
      if (!fifo_empty && TX_RDY) begin
        tx_stb_d = 1'b1;
        tx_dat_d = fifo_mem[rd_ptr_q];
      end
    end else if (TX_ACK) begin
      tx_stb_d = 1'b0;
    end
    // Verify never fills the FIFO, so the driver is never throttled there.
    res_busy_d = (count_d >= (FIFO_AW+1)'(DEPTH - 4)) && (cmd_q != CMD_V);
  end

  always_ff @(posedge CLOCK50) begin
    if (push_en) fifo_mem[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge CLOCK50 or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      arg_cnt_q  <= '0;
      addr_q     <= '0;
      mode_q     <= 8'h00;
      seed_q     <= 8'h41;
      pat_q      <= '0;
      cnt_q      <= '0;
      mis_q      <= '0;
      resp_q     <= '0;
      resp_idx_q <= '0;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_stb_q   <= 1'b0;
      tx_dat_q   <= '0;
      res_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_cnt_q  <= arg_cnt_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
      resp_q     <= resp_d;
      resp_idx_q <= resp_idx_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_stb_q   <= tx_stb_d;
      tx_dat_q   <= tx_dat_d;
      res_busy_q <= res_busy_d;
    end
  end

  assign WR_STB    = (state_q == S_REQ) && (cmd_q == CMD_Z);
  assign RD_STB    = (state_q == S_REQ) && (cmd_q != CMD_Z);
  assign WD_STB    = (state_q == S_WSTREAM);
  assign WR_ADDR   = addr_q[AW-1:0];
  assign RD_ADDR   = addr_q[AW-1:0];
  assign WD_DATA   = pat_q;
  assign TX_STB    = tx_stb_q;
  assign TX_DAT    = tx_dat_q;
  assign RES_BUSY  = res_busy_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sd_card_test_sequencer.sv
// Directed testbench for sd_card_test_sequencer: write, dump, verify,
// pattern modes, timeout, unknown command and mid-operation reset.
module tb_sd_card_test_sequencer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        rx_stb, tx_stb, tx_ack, tx_rdy;
  logic [7:0]  rx_dat, tx_dat;
  logic        wr_stb, wr_ack, wd_stb, wd_ack, rd_stb, rd_ack, res_stb, res_busy;
  logic [31:0] wr_addr, rd_addr;
  logic [7:0]  wd_data, res_data;
  logic [2:0]  dbg_state;

  logic        tx_en;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          total = 0;
  int          bad   = 0;

  sd_card_test_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .CLOCK50(clk), .nRESET(n_reset),
    .RX_STB(rx_stb), .RX_DAT(rx_dat),
    .TX_STB(tx_stb), .TX_DAT(tx_dat), .TX_ACK(tx_ack), .TX_RDY(tx_rdy),
    .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_ACK(wr_ack),
    .WD_STB(wd_stb), .WD_DATA(wd_data), .WD_ACK(wd_ack),
    .RD_STB(rd_stb), .RD_ADDR(rd_addr), .RD_ACK(rd_ack),
    .RES_STB(res_stb), .RES_DATA(res_data), .RES_BUSY(res_busy),
    .DBG_STATE(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- UART model: capture and ack on the falling edge --------
  always @(negedge clk) begin
    tx_rdy = tx_en;
    if (tx_stb && tx_en) begin
      got_q.push_back(tx_dat);
      tx_ack = 1'b1;
    end else begin
      tx_ack = 1'b0;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_stb = 1'b1;
    rx_dat = b;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a);
    send_byte(c);
    for (int k = 3; k >= 0; k--) send_byte(a[k*8 +: 8]);
  endtask

  task automatic send_pat(input logic [7:0] mode, input logic [7:0] seed);
    send_byte(8'h70);
    send_byte(mode);
    send_byte(seed);
  endtask

  task automatic pulse_wr_ack();
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  task automatic pulse_rd_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  // Capture the current write byte, then acknowledge it.
  task automatic ack_wd(output logic [7:0] d, output logic stb);
    d   = wd_data;
    stb = wd_stb;
    wd_ack = 1'b1;
    @(negedge clk);
    wd_ack = 1'b0;
    @(negedge clk);
  endtask

  // Deliver one read byte, honouring RES_BUSY with a bounded wait.
  task automatic feed(input logic [7:0] d);
    int n = 0;
    while (res_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) check("busy_wait", {31'd0, res_busy}, 32'd0);
    res_stb  = 1'b1;
    res_data = d;
    @(negedge clk);
    res_stb = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: wait for the expected byte count, then compare in order.
  task automatic wait_tx(input string tag, input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    logic       s;
    logic [7:0] lfsr_exp[5];
    int         n;

`ifdef SD_TESTER_LFSR_EN
    lfsr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
`else
    lfsr_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`endif

    n_reset = 1'b0; rx_stb = 1'b0; rx_dat = 8'h00; tx_ack = 1'b0; tx_rdy = 1'b0;
    wr_ack = 1'b0; wd_ack = 1'b0; rd_ack = 1'b0; res_stb = 1'b0; res_data = 8'h00;
    tx_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_rd_stb", {31'd0, rd_stb}, 32'd0);
    check("rst_wd_stb", {31'd0, wd_stb}, 32'd0);
    check("rst_tx_stb", {31'd0, tx_stb}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wd_data", {24'd0, wd_data}, 32'd0);
    check("rst_tx_dat", {24'd0, tx_dat}, 32'd0);
    check("rst_res_busy", {31'd0, res_busy}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // Write: incrementing pattern from 0x41
    send_pat(8'h00, 8'h41);
    exp_q.push_back(8'h4B);
    wait_tx("pat_resp", 100);
    send_cmd(8'h7A, 32'd8);
    check("wr_stb_rise", {31'd0, wr_stb}, 32'd1);
    check("wr_addr", wr_addr, 32'd8);
    repeat (3) @(negedge clk);
    check("wr_stb_hold", {31'd0, wr_stb}, 32'd1);
    pulse_wr_ack();
    check("wr_stb_fall", {31'd0, wr_stb}, 32'd0);
    for (int i = 0; i < 512; i++) begin
      ack_wd(d, s);
      check("wd_stb", {31'd0, s}, 32'd1);
      check("wd_data", {24'd0, d}, {24'd0, 8'(8'h41 + i)});
    end
    check("wd_stb_end", {31'd0, wd_stb}, 32'd0);
    exp_q.push_back(8'h4B);
    wait_tx("write_resp", 100);

    // Dump with the UART stalled at first
    tx_en = 1'b0;
    @(negedge clk);
    send_cmd(8'h6F, 32'd2);
    check("rd_stb_rise", {31'd0, rd_stb}, 32'd1);
    check("rd_addr", rd_addr, 32'd2);
    pulse_rd_ack();
    for (int i = 0; i < 512; i++) begin
      if (i == 59) check("busy_at_59", {31'd0, res_busy}, 32'd0);
      if (i == 60) begin
        check("busy_at_60", {31'd0, res_busy}, 32'd1);
        tx_en = 1'b1;
      end
      feed(8'(i));
      exp_q.push_back(8'(i));
    end
    exp_q.push_back(8'h4B);
    wait_tx("dump", 3000);

    // Verify: constant pattern, clean then with 3 corrupted bytes
    send_pat(8'h01, 8'hA5);
    exp_q.push_back(8'h4B);
    wait_tx("pat1_resp", 100);
    send_cmd(8'h76, 32'd0);
    pulse_rd_ack();
    for (int i = 0; i < 512; i++) feed(8'hA5);
    check("verify_busy", {31'd0, res_busy}, 32'd0);
    exp_q.push_back(8'h50);
    wait_tx("verify_pass", 100);
    send_cmd(8'h76, 32'd1);
    pulse_rd_ack();
    for (int i = 0; i < 512; i++) feed((i == 10 || i == 200 || i == 511) ? 8'h5A : 8'hA5);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    wait_tx("verify_fail", 100);

    // Mode 2 pattern
    send_pat(8'h02, 8'h00);
    exp_q.push_back(8'h4B);
    wait_tx("pat2_resp", 100);
    send_cmd(8'h7A, 32'd0);
    pulse_wr_ack();
    for (int i = 0; i < 512; i++) begin
      ack_wd(d, s);
      if (i < 5) check("lfsr_data", {24'd0, d}, {24'd0, lfsr_exp[i]});
    end
    exp_q.push_back(8'h4B);
    wait_tx("lfsr_resp", 100);

    // Timeout: WR_ACK never comes
    send_cmd(8'h7A, 32'd1);
    n = 0;
    while (wr_stb && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 32'd100);
    exp_q.push_back(8'h54);
    wait_tx("timeout_resp", 100);
    send_cmd(8'h6F, 32'd3);
    check("after_to_rd_stb", {31'd0, rd_stb}, 32'd1);
    check("after_to_rd_addr", rd_addr, 32'd3);
    pulse_rd_ack();
    for (int i = 0; i < 512; i++) begin
      d = 8'($urandom_range(0, 255));
      feed(d);
      exp_q.push_back(d);
    end
    exp_q.push_back(8'h4B);
    wait_tx("dump2", 3000);

    // Unknown command
    send_byte(8'h78);
    exp_q.push_back(8'h3F);
    wait_tx("unknown", 100);

    // Mid-operation reset with bytes waiting in the FIFO
    tx_en = 1'b0;
    @(negedge clk);
    send_byte(8'h78);
    send_pat(8'h01, 8'h33);
    send_cmd(8'h7A, 32'd5);
    pulse_wr_ack();
    for (int i = 0; i < 3; i++) ack_wd(d, s);
    check("pre_rst_wd_stb", {31'd0, wd_stb}, 32'd1);
    #2 n_reset = 1'b0;
    #1;
    check("async_wd_stb", {31'd0, wd_stb}, 32'd0);
    check("async_state", {29'd0, dbg_state}, 32'd0);
    check("async_wd_data", {24'd0, wd_data}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    tx_en = 1'b1;
    repeat (10) @(negedge clk);
    check("fifo_flushed", got_q.size(), 32'd0);
    got_q.delete();
    send_cmd(8'h7A, 32'd4);
    pulse_wr_ack();
    for (int i = 0; i < 512; i++) begin
      ack_wd(d, s);
      if (i < 2) check("default_pat", {24'd0, d}, {24'd0, 8'(8'h41 + i)});
    end
    exp_q.push_back(8'h4B);
    wait_tx("post_rst_resp", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
